// File: rtl/ripple_adder_5bit.sv
// rtl/ripple_adder_5bit.sv - unsigned ripple-carry adder with combinational and registered, valid-qualified result
module ripple_adder_5bit #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum_comb,
    output logic [WIDTH:0]   sum,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_bits;
    logic             carry_out;

    // Full-adder cells chained LSB to MSB; carry is walked as a scalar so the chain is not a self-referencing vector.
    always_comb begin
        logic carry;
        logic prop;
        carry    = 1'b0;
        sum_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prop        = a[i] ^ b[i];
            sum_bits[i] = prop ^ carry;
            carry       = (a[i] & b[i]) | (carry & prop);
        end
        carry_out = carry;
    end

    assign sum_comb = {carry_out, sum_bits};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= sum_comb;
            end
        end
    end

endmodule

// File: tb/tb_ripple_adder_5bit.sv
// tb/tb_ripple_adder_5bit.sv - directed and exhaustive self-checking bench for ripple_adder_5bit
module tb_ripple_adder_5bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] sum_comb;
    logic [5:0] sum;
    logic       out_valid;

    int errors;
    int checks;

    logic [5:0] exp_sum;
    logic       exp_valid;

    ripple_adder_5bit #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum_comb  (sum_comb),
        .sum       (sum),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d (%b) expected=%0d (%b)", tag, observed, observed, expected, expected);
        end
    endtask

    // Drive inputs away from the active edge, then let combinational logic settle.
    task automatic apply(input logic r, input logic v, input logic [4:0] av, input logic [4:0] bv);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a        = av;
        b        = bv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 5'd31;
        b        = 5'd31;

        // Reset held two cycles with valid operands present
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 5'd31, 5'd31);
            check("reset_sum_comb", sum_comb, 6'd62);
            tick();
            check("reset_sum", sum, 6'd0);
            check("reset_out_valid", {5'd0, out_valid}, 6'd0);
            check("reset_sum_comb_after_edge", sum_comb, 6'd62);
        end

        // Max carry propagation
        apply(1'b1, 1'b1, 5'b11111, 5'b00001);
        check("max_carry_comb", sum_comb, 6'b100000);
        tick();
        check("max_carry_sum", sum, 6'd32);
        check("max_carry_valid", {5'd0, out_valid}, 6'd1);

        // Multiplier-row style operands
        apply(1'b1, 1'b0, 5'b00111, 5'b01110);
        check("row_7_14", sum_comb, 6'd21);
        apply(1'b1, 1'b0, 5'b11100, 5'b10101);
        check("row_28_21", sum_comb, 6'd49);

        // Back-to-back results then hold
        apply(1'b1, 1'b1, 5'd3, 5'd4);
        tick();
        check("b2b_sum_7", sum, 6'd7);
        check("b2b_valid_7", {5'd0, out_valid}, 6'd1);
        apply(1'b1, 1'b1, 5'd10, 5'd20);
        tick();
        check("b2b_sum_30", sum, 6'd30);
        check("b2b_valid_30", {5'd0, out_valid}, 6'd1);
        apply(1'b1, 1'b1, 5'd31, 5'd0);
        tick();
        check("b2b_sum_31", sum, 6'd31);
        check("b2b_valid_31", {5'd0, out_valid}, 6'd1);
        apply(1'b1, 1'b0, 5'd9, 5'd9);
        tick();
        check("hold_sum", sum, 6'd31);
        check("hold_valid", {5'd0, out_valid}, 6'd0);
        apply(1'b1, 1'b0, 5'd1, 5'd2);
        tick();
        check("hold_sum_2", sum, 6'd31);

        // Reset mid-stream discards the pair presented with it
        apply(1'b1, 1'b1, 5'd8, 5'd9);
        tick();
        check("mid_pre_sum", sum, 6'd17);
        apply(1'b0, 1'b1, 5'd12, 5'd5);
        check("mid_rst_comb", sum_comb, 6'd17);
        tick();
        check("mid_rst_sum", sum, 6'd0);
        check("mid_rst_valid", {5'd0, out_valid}, 6'd0);
        apply(1'b1, 1'b1, 5'd1, 5'd1);
        tick();
        check("mid_post_sum", sum, 6'd2);
        check("mid_post_valid", {5'd0, out_valid}, 6'd1);

        // Exhaustive sweep with randomly toggled in_valid against a one-cycle-delayed model
        exp_sum   = 6'd2;
        exp_valid = 1'b1;
        for (int ai = 0; ai < 32; ai++) begin
            for (int bi = 0; bi < 32; bi++) begin
                logic v;
                logic [5:0] want;
                v    = 1'($urandom_range(0, 1));
                want = 6'(ai) + 6'(bi);
                apply(1'b1, v, 5'(ai), 5'(bi));
                check("exh_comb", sum_comb, want);
                tick();
                if (v) exp_sum = want;
                exp_valid = v;
                check("exh_sum", sum, exp_sum);
                check("exh_valid", {5'd0, out_valid}, {5'd0, exp_valid});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
